mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer and two-port arbiter in front of the processor's 4 KB byte-addressed main memory. Accepts scalar (8-bit), half-vector (32-bit) and vector (64-bit) load/store requests from two requesters (port 0: instruction/scalar unit, port 1: vector unit). Grants them round-robin and drives the memory's four enable lines and its address and write-data lines for exactly one cycle per access. Returns registered, zero-extended read data with a one-cycle done pulse and range checking.

## Interface
- `ADDR_W`, 12, byte address width; memory size is 2^ADDR_W bytes
- `DATA_W`, 64, data width; fixed at 64
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `req0` / `req1` in 1: access request; held until `gnt0` / `gnt1` is seen
- `we0` / `we1` in 1: 1 = store, 0 = load
- `size0` / `size1` in 2: 00 byte, 01 word32, 10 vec64, 11 illegal
- `addr0` / `addr1` in 12: byte start address; little-endian (lowest byte at `addr`)
- `wdata0` / `wdata1` in 64: store data; bits [7:0] for byte stores, [31:0] for word stores
- `gnt0` / `gnt1` out 1: one-cycle pulse; the request was latched and the requester may change its inputs
- `done0` / `done1` out 1: one-cycle completion pulse
- `rdata` out 64: load result; valid only while a `done` is high
- `err` out 1: valid with `done`; 1 = illegal size or out-of-range access
- `mem_address` out 12: to memory
- `mem_readEnable`, `mem_writeEnable`, `mem_vectorReadEnable`, `mem_vectorWriteEnable` out 1 each: to memory
- `mem_dataIn` out 64: to memory
- `mem_dataOut` in 64: from memory; combinational read data

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:** if any `req` is high, select a port, latch its cmd/addr/wdata into internal registers, then go to ACCESS. Otherwise stay in IDLE.
- **Arbitration:** round-robin with a 1-bit `last` register, reset to 1.
  - Both requesting: grant the port that is not `last`.
  - One requesting: grant that port.
  - `last` updates on every grant.
- **Legality check** at latch time:
  - size 11 is an error.
  - Out of range when addr + bytes − 1 > 4095, where bytes = 1, 4 or 8.
  - An erroneous command skips memory: enables stay 0 in ACCESS and the response has `err`=1 and `rdata`=0.
- **ACCESS (one cycle):** `gnt` of the chosen port is high. `mem_address` and `mem_dataIn` come from the latched values. Exactly one enable encoding is driven:
  - byte load: readEnable
  - word load: readEnable + vectorReadEnable
  - vec load: vectorReadEnable
  - byte store: writeEnable
  - word store: writeEnable + vectorWriteEnable
  - vec store: vectorWriteEnable
- **Read capture:** at the end of ACCESS, `mem_dataOut` is registered into `rdata`.
  - Byte loads are forced to {56'b0, byte}.
  - Word loads are forced to {32'b0, word}.
  - Stores give `rdata`=0.
  - Then go to RESP.
- **RESP (one cycle):** `done` of the served port is high, and `rdata`/`err` are valid. Go to IDLE.
- **Outputs outside ACCESS:** all memory enables are 0, and `mem_address` / `mem_dataIn` hold their last value.
- **Request changes:** a requester changing or dropping `req` before `gnt` has no effect on a latched command. An un-granted request keeps waiting.

## Timing
- **Reset values:** state IDLE, `last`=1, and all of these outputs 0: `gnt*`, `done*`, `err`, `rdata`, `mem_*` enables, `mem_address`, `mem_dataIn`.
- **Latency:** with `req` sampled high at edge N (FSM in IDLE):
  - ACCESS and `gnt` during cycle N+1
  - `done` during cycle N+2
  - earliest next grant: ACCESS during cycle N+4
  - throughput: one access per 3 cycles
- **No overlap:** `gnt` and `done` are never high for both ports in the same cycle, and never high for the same port in the same cycle.
- **Registered outputs:** enables, address and write data come from registers, which gives glitch-free memory writes.
- **Simultaneous requests:** after reset port 0 wins, then port 1 is served next. Continuous dual requests alternate 0, 1, 0, 1.
- **Reset mid-operation:** `rst` high in ACCESS or RESP returns to IDLE at that edge. Enables drop and the pending `done` is suppressed. A store already enabled during ACCESS may have been written.
- **Address wrap:** never occurs, because the range check blocks it.

## Test plan
- **Vector load:** memory bytes 0–7 = 17 2B 64 1E 44 36 4B C9, port 1 vec load at addr 0 → `rdata`=0xC94B36441E642B17, `err`=0, `done1` 2 cycles after `req1` is sampled, `mem_vectorReadEnable` high for exactly 1 cycle.
- **Store then loads:** port 1 vec store of 0x1122334455667788 at 0x100, then port 0 byte load at 0x103 → 0x0000000000000055. Then port 0 word load at 0x100 → 0x0000000055667788.
- **Arbitration:** `req0` and `req1` high from reset for 4 accesses → grant order 0, 1, 0, 1, with each `gnt` spaced 3 cycles apart.
- **Illegal accesses:** port 0 vec load at 0xFFC → `err`=1, `rdata`=0, no enable ever high. Size 11 → same. Byte load at 0xFFF → `err`=0.
- **Reset mid-access:** `rst` asserted during ACCESS → no `done`, all outputs at reset values next cycle, then the next request is served normally from port 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Two-port round-robin sequencer in front of the byte-addressed main memory.
// Each request is latched, range-checked, issued to memory for one cycle, then answered with done/rdata/err.
module mem_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [1:0]        size0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [1:0]        size1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_readEnable,
    output logic              mem_writeEnable,
    output logic              mem_vectorReadEnable,
    output logic              mem_vectorWriteEnable,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              last;
    logic              port_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              err_q;

    logic              pick;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W:0]   span;
    logic [ADDR_W:0]   end_addr;
    logic              sel_err;
    logic [DATA_W-1:0] load_data;

    // Port selection and legality of the command about to be latched; a carry
    // out of the last-byte address means the access would run past the top.
    always_comb begin
        pick      = (req0 && req1) ? ~last : req1;
        sel_we    = pick ? we1    : we0;
        sel_size  = pick ? size1  : size0;
        sel_addr  = pick ? addr1  : addr0;
        sel_wdata = pick ? wdata1 : wdata0;
        case (sel_size)
            2'b00:   span = (ADDR_W+1)'(0);
            2'b01:   span = (ADDR_W+1)'(3);
            2'b10:   span = (ADDR_W+1)'(7);
            default: span = (ADDR_W+1)'(0);
        endcase
        end_addr = {1'b0, sel_addr} + span;
        sel_err  = (sel_size == 2'b11) || end_addr[ADDR_W];
    end

    always_comb begin
        load_data = '0;
        if (!err_q && !we_q) begin
            case (size_q)
                2'b00:   load_data = {{(DATA_W-8){1'b0}}, mem_dataOut[7:0]};
                2'b01:   load_data = {{(DATA_W-32){1'b0}}, mem_dataOut[31:0]};
                2'b10:   load_data = mem_dataOut;
                default: load_data = '0;
            endcase
        end
    end

    // Pulses (gnt, done, enables) default low every cycle so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            last                  <= 1'b1;
            port_q                <= 1'b0;
            we_q                  <= 1'b0;
            size_q                <= 2'b00;
            err_q                 <= 1'b0;
            gnt0                  <= 1'b0;
            gnt1                  <= 1'b0;
            done0                 <= 1'b0;
            done1                 <= 1'b0;
            rdata                 <= '0;
            err                   <= 1'b0;
            mem_address           <= '0;
            mem_dataIn            <= '0;
            mem_readEnable        <= 1'b0;
            mem_writeEnable       <= 1'b0;
            mem_vectorReadEnable  <= 1'b0;
            mem_vectorWriteEnable <= 1'b0;
        end else begin
            gnt0                  <= 1'b0;
            gnt1                  <= 1'b0;
            done0                 <= 1'b0;
            done1                 <= 1'b0;
            mem_readEnable        <= 1'b0;
            mem_writeEnable       <= 1'b0;
            mem_vectorReadEnable  <= 1'b0;
            mem_vectorWriteEnable <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        port_q      <= pick;
                        last        <= pick;
                        we_q        <= sel_we;
                        size_q      <= sel_size;
                        err_q       <= sel_err;
                        mem_address <= sel_addr;
                        mem_dataIn  <= sel_wdata;
                        gnt0        <= ~pick;
                        gnt1        <= pick;
                        if (!sel_err) begin
                            mem_readEnable        <= !sel_we && (sel_size == 2'b00 || sel_size == 2'b01);
                            mem_vectorReadEnable  <= !sel_we && (sel_size == 2'b01 || sel_size == 2'b10);
                            mem_writeEnable       <=  sel_we && (sel_size == 2'b00 || sel_size == 2'b01);
                            mem_vectorWriteEnable <=  sel_we && (sel_size == 2'b01 || sel_size == 2'b10);
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata <= load_data;
                    err   <= err_q;
                    done0 <= ~port_q;
                    done1 <= port_q;
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-array reference model predicts grant order,
// memory enables and responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_access_ctrl;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [11:0] addr;
        logic [63:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic [3:0]  en;
        logic [11:0] addr;
        logic [63:0] data;
    } memop_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [1:0]  size0 = '0, size1 = '0;
    logic [11:0] addr0 = '0, addr1 = '0;
    logic [63:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, done0, done1, err;
    logic [63:0] rdata;
    logic [11:0] mem_address;
    logic        mem_readEnable, mem_writeEnable, mem_vectorReadEnable, mem_vectorWriteEnable;
    logic [63:0] mem_dataIn;
    logic [63:0] mem_dataOut;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        seed_mem = 1'b1;
    logic        last_m = 1'b1;
    logic [7:0]  refmem [0:4095];
    logic [7:0]  dmem [0:4095];
    int          dev_nb;

    int          gq[$];
    memop_t      eq[$];
    resp_t       dq0[$];
    resp_t       dq1[$];
    logic        prev_gnt0 = 1'b0, prev_gnt1 = 1'b0;

    mem_access_ctrl #(.ADDR_W(12), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err), .mem_address(mem_address),
        .mem_readEnable(mem_readEnable), .mem_writeEnable(mem_writeEnable),
        .mem_vectorReadEnable(mem_vectorReadEnable), .mem_vectorWriteEnable(mem_vectorWriteEnable),
        .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: combinational little-endian read, byte count of writes decoded from the enable pair.
    always_comb begin
        mem_dataOut = '0;
        for (int i = 0; i < 8; i++)
            mem_dataOut[8*i +: 8] = dmem[12'(int'(mem_address) + i)];
    end

    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= refmem[i];
        end else if (mem_writeEnable || mem_vectorWriteEnable) begin
            dev_nb = mem_vectorWriteEnable ? (mem_writeEnable ? 4 : 8) : 1;
            for (int i = 0; i < dev_nb; i++)
                dmem[12'(int'(mem_address) + i)] <= mem_dataIn[8*i +: 8];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] encOf(input logic we, input logic [1:0] size);
        // {readEnable, writeEnable, vectorReadEnable, vectorWriteEnable}
        if (!we) return (size == 2'b00) ? 4'b1000 : (size == 2'b01) ? 4'b1010 : 4'b0010;
        else     return (size == 2'b00) ? 4'b0100 : (size == 2'b01) ? 4'b0101 : 4'b0001;
    endfunction

    // Reference behaviour of one served command, in service order.
    task automatic modelAccess(input logic port, input cmd_t c);
        int    nbytes;
        resp_t r;
        nbytes = (c.size == 2'b00) ? 1 : (c.size == 2'b01) ? 4 : 8;
        r.err   = (c.size == 2'b11) || (int'(c.addr) + nbytes - 1 > 4095);
        r.rdata = '0;
        if (!r.err) begin
            eq.push_back('{en: encOf(c.we, c.size), addr: c.addr, data: c.wdata});
            for (int i = 0; i < nbytes; i++) begin
                if (c.we) refmem[int'(c.addr) + i] = c.wdata[8*i +: 8];
                else      r.rdata[8*i +: 8] = refmem[int'(c.addr) + i];
            end
        end
        gq.push_back(int'(port));
        if (port) dq1.push_back(r); else dq0.push_back(r);
        last_m = port;
    endtask

    task automatic drivePort(input logic port, input cmd_t c);
        if (port) begin we1 = c.we; size1 = c.size; addr1 = c.addr; wdata1 = c.wdata; end
        else      begin we0 = c.we; size0 = c.size; addr0 = c.addr; wdata0 = c.wdata; end
    endtask

    function automatic cmd_t randCmd();
        cmd_t c;
        c.we    = 1'($urandom);
        c.size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        c.addr  = ($urandom_range(0, 4) == 0) ? 12'(4095 - $urandom_range(0, 9)) : 12'($urandom);
        c.wdata = {$urandom, $urandom};
        return c;
    endfunction

    // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle again.
    task automatic applyStimulus(input logic v0, input cmd_t c0, input logic v1, input cmd_t c1);
        logic first;
        logic p0, p1;
        int   n, g0c, g1c, firstLat;
        first = (v0 && v1) ? ~last_m : v1;
        modelAccess(first, first ? c1 : c0);
        if (v0 && v1) modelAccess(~first, first ? c0 : c1);
        if (v0) begin drivePort(1'b0, c0); req0 = 1'b1; end
        if (v1) begin drivePort(1'b1, c1); req1 = 1'b1; end
        p0 = v0; p1 = v1; n = 0; g0c = 0; g1c = 0; firstLat = -1;
        while ((p0 || p1) && n < 20) begin
            @(posedge clk); #1; n++;
            if (p0 && gnt0) begin
                p0 = 1'b0; g0c = cyc; req0 = 1'b0; drivePort(1'b0, randCmd());
                if (firstLat < 0) firstLat = n;
            end
            if (p1 && gnt1) begin
                p1 = 1'b0; g1c = cyc; req1 = 1'b0; drivePort(1'b1, randCmd());
                if (firstLat < 0) firstLat = n;
            end
        end
        if (p0 || p1) begin
            total++; bad++;
            $display("[TB] FAIL grant_timeout: pending p0=%0d p1=%0d after %0d cycles", p0, p1, n);
            req0 = 1'b0; req1 = 1'b0;
        end else begin
            checkOutput("grant_latency", 64'(firstLat), 64'd1);
            if (v0 && v1) checkOutput("dual_grant_spacing", 64'(g0c > g1c ? g0c - g1c : g1c - g0c), 64'd3);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_gnt"}, {62'b0, gnt1, gnt0}, 64'd0);
        checkOutput({tag, "_done"}, {62'b0, done1, done0}, 64'd0);
        checkOutput({tag, "_err"}, {63'b0, err}, 64'd0);
        checkOutput({tag, "_rdata"}, rdata, 64'd0);
        checkOutput({tag, "_en"}, {60'b0, mem_readEnable, mem_writeEnable, mem_vectorReadEnable, mem_vectorWriteEnable}, 64'd0);
        checkOutput({tag, "_addr"}, {52'b0, mem_address}, 64'd0);
        checkOutput({tag, "_dataIn"}, mem_dataIn, 64'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        last_m = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every grant, memory strobe and done is matched against the scoreboard.
    always @(negedge clk) begin
        logic [3:0] en;
        memop_t     m;
        resp_t      r;
        en = {mem_readEnable, mem_writeEnable, mem_vectorReadEnable, mem_vectorWriteEnable};
        if (gnt0 || gnt1 || done0 || done1)
            checkOutput("one_hot_pulses", 64'(int'(gnt0) + int'(gnt1) + int'(done0) + int'(done1)), 64'd1);
        if (gnt0 || gnt1) begin
            if (gq.size() == 0) checkOutput("unexpected_grant", {62'b0, gnt1, gnt0}, 64'd0);
            else checkOutput("grant_port", 64'(gnt1), 64'(gq.pop_front()));
        end
        if (en != 4'b0000) begin
            if (eq.size() == 0) checkOutput("unexpected_enable", 64'(en), 64'd0);
            else begin
                m = eq.pop_front();
                checkOutput("enable_code", 64'(en), 64'(m.en));
                checkOutput("mem_address", 64'(mem_address), 64'(m.addr));
                checkOutput("mem_dataIn", mem_dataIn, m.data);
                checkOutput("enable_in_access", 64'(gnt0 | gnt1), 64'd1);
            end
        end
        if (done0) begin
            checkOutput("done0_after_gnt0", 64'(prev_gnt0), 64'd1);
            if (dq0.size() == 0) checkOutput("unexpected_done0", 64'd1, 64'd0);
            else begin
                r = dq0.pop_front();
                checkOutput("rdata_port0", rdata, r.rdata);
                checkOutput("err_port0", 64'(err), 64'(r.err));
            end
        end
        if (done1) begin
            checkOutput("done1_after_gnt1", 64'(prev_gnt1), 64'd1);
            if (dq1.size() == 0) checkOutput("unexpected_done1", 64'd1, 64'd0);
            else begin
                r = dq1.pop_front();
                checkOutput("rdata_port1", rdata, r.rdata);
                checkOutput("err_port1", 64'(err), 64'(r.err));
            end
        end
        prev_gnt0 <= gnt0;
        prev_gnt1 <= gnt1;
    end

    initial begin
        cmd_t c0, c1, nc;
        logic [7:0] seed [0:7];
        logic       v0, v1;
        seed = '{8'h17, 8'h2B, 8'h64, 8'h1E, 8'h44, 8'h36, 8'h4B, 8'hC9};
        for (int i = 0; i < 4096; i++) refmem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) refmem[i] = seed[i];
        nc = '0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        seed_mem = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Vector load from the seeded bytes, then a store followed by narrower loads.
        applyStimulus(1'b0, nc, 1'b1, '{we: 1'b0, size: 2'b10, addr: 12'h000, wdata: 64'h0});
        applyStimulus(1'b0, nc, 1'b1, '{we: 1'b1, size: 2'b10, addr: 12'h100, wdata: 64'h1122334455667788});
        applyStimulus(1'b1, '{we: 1'b0, size: 2'b00, addr: 12'h103, wdata: 64'h0}, 1'b0, nc);
        applyStimulus(1'b1, '{we: 1'b0, size: 2'b01, addr: 12'h100, wdata: 64'h0}, 1'b0, nc);

        // Dual requests straight from reset: 0, 1, 0, 1.
        doReset();
        for (int k = 0; k < 2; k++)
            applyStimulus(1'b1, randCmd(), 1'b1, randCmd());

        // Range and size boundaries.
        applyStimulus(1'b1, '{we: 1'b0, size: 2'b10, addr: 12'hFFC, wdata: 64'h0}, 1'b0, nc);
        applyStimulus(1'b1, '{we: 1'b1, size: 2'b11, addr: 12'h010, wdata: 64'hFFFF}, 1'b0, nc);
        applyStimulus(1'b1, '{we: 1'b0, size: 2'b00, addr: 12'hFFF, wdata: 64'h0}, 1'b0, nc);
        applyStimulus(1'b1, '{we: 1'b0, size: 2'b10, addr: 12'hFF8, wdata: 64'h0}, 1'b0, nc);
        applyStimulus(1'b0, nc, 1'b1, '{we: 1'b1, size: 2'b01, addr: 12'hFFD, wdata: 64'h1234});
        applyStimulus(1'b0, nc, 1'b1, '{we: 1'b1, size: 2'b01, addr: 12'hFFC, wdata: 64'hA5A5_5A5A});

        // Reset while in ACCESS: grant and strobe appear, done never does.
        gq.push_back(0);
        eq.push_back('{en: 4'b0010, addr: 12'h040, data: 64'h0});
        drivePort(1'b0, '{we: 1'b0, size: 2'b10, addr: 12'h040, wdata: 64'h0});
        req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        checkOutput("midrst_gnt0", 64'(gnt0), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("midrst");
        rst = 1'b0;
        last_m = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, randCmd(), 1'b1, randCmd());

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            c0 = randCmd();
            c1 = randCmd();
            applyStimulus(v0, c0, v1, c1);
        end

        repeat (5) @(negedge clk);
        checkOutput("grants_drained", 64'(gq.size()), 64'd0);
        checkOutput("memops_drained", 64'(eq.size()), 64'd0);
        checkOutput("resp0_drained", 64'(dq0.size()), 64'd0);
        checkOutput("resp1_drained", 64'(dq1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
